// File: rtl/interface_input_pipe.sv
// Handshaked CORDIC input stage: iteratively wraps an angle into (-180,180], then folds it into
// a sector code plus a [0,90] residual. Arctan mode instead folds (x,y) into the right half-plane.
module interface_input_pipe #(
    parameter int unsigned INPUT_WIDTH       = 16,
    parameter int unsigned INPUT_FRAC_WIDTH  = 4,
    parameter int unsigned OUTPUT_WIDTH      = 16,
    parameter int unsigned SECTOR_FLAG_WIDTH = 2,
    parameter int unsigned MAX_WRAP_STEPS    = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                valid_in,
    output logic                                ready_out,
    input  logic signed [INPUT_WIDTH-1:0]       degree_in,
    input  logic signed [INPUT_WIDTH-1:0]       x_in,
    input  logic signed [INPUT_WIDTH-1:0]       y_in,
    input  logic                                arctan_en_in,
    output logic                                valid_out,
    input  logic                                ready_in,
    output logic        [OUTPUT_WIDTH-1:0]      degree_out,
    output logic signed [INPUT_WIDTH-1:0]       x_out,
    output logic signed [INPUT_WIDTH-1:0]       y_out,
    output logic        [SECTOR_FLAG_WIDTH-1:0] sector_out,
    output logic                                arctan_en_out,
    output logic                                wrap_err
);

    localparam int AW    = INPUT_WIDTH + 1;
    localparam int FW    = INPUT_WIDTH + 2;
    localparam int SW    = $clog2(MAX_WRAP_STEPS + 2);
    localparam int SCALE = 1 << INPUT_FRAC_WIDTH;

    localparam logic signed [AW-1:0] C90  = AW'(90 * SCALE);
    localparam logic signed [AW-1:0] C180 = AW'(180 * SCALE);
    localparam logic signed [AW-1:0] C360 = AW'(360 * SCALE);

    localparam logic [SECTOR_FLAG_WIDTH-1:0] SecS1 = SECTOR_FLAG_WIDTH'(2'b00);
    localparam logic [SECTOR_FLAG_WIDTH-1:0] SecS2 = SECTOR_FLAG_WIDTH'(2'b10);
    localparam logic [SECTOR_FLAG_WIDTH-1:0] SecS3 = SECTOR_FLAG_WIDTH'(2'b11);
    localparam logic [SECTOR_FLAG_WIDTH-1:0] SecS4 = SECTOR_FLAG_WIDTH'(2'b01);

    localparam logic signed [INPUT_WIDTH-1:0] SMin = {1'b1, {(INPUT_WIDTH-1){1'b0}}};
    localparam logic signed [INPUT_WIDTH-1:0] SMax = ~SMin;

    typedef enum logic [1:0] {StIdle, StReduce, StOut} state_t;

    state_t                          r_state;
    logic signed [AW-1:0]            r_a;
    logic signed [INPUT_WIDTH-1:0]   r_x;
    logic signed [INPUT_WIDTH-1:0]   r_y;
    logic                            r_mode;
    logic        [SW-1:0]            r_steps;

    logic                            w_accept;
    logic                            w_hi;
    logic                            w_lo;
    logic                            w_out_range;
    logic signed [FW-1:0]            w_a_ext;
    logic signed [FW-1:0]            w_fold_val;
    logic        [SECTOR_FLAG_WIDTH-1:0] w_fold_sec;
    logic signed [INPUT_WIDTH-1:0]   w_neg_x;
    logic signed [INPUT_WIDTH-1:0]   w_neg_y;

    assign ready_out   = (r_state == StIdle) || ((r_state == StOut) && ready_in);
    assign valid_out   = (r_state == StOut);
    assign w_accept    = valid_in && ready_out;
    assign w_hi        = r_a > C180;
    assign w_lo        = r_a <= -C180;
    assign w_out_range = w_hi || w_lo;

    // Saturate so the most negative component still flips to a positive value.
    assign w_neg_x = (r_x == SMin) ? SMax : -r_x;
    assign w_neg_y = (r_y == SMin) ? SMax : -r_y;

    always_comb begin
        w_a_ext    = FW'(r_a);
        w_fold_val = w_a_ext;
        w_fold_sec = SecS1;
        if (r_a >= C90) begin
            w_fold_sec = SecS2;
            w_fold_val = w_a_ext - FW'(C90);
        end else if (r_a > 0) begin
            w_fold_sec = SecS1;
            w_fold_val = w_a_ext;
        end else if (r_a <= -C90) begin
            w_fold_sec = SecS3;
            w_fold_val = w_a_ext + FW'(C180);
        end else begin
            w_fold_sec = SecS4;
            w_fold_val = w_a_ext + FW'(C90);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= StIdle;
            r_a           <= '0;
            r_x           <= '0;
            r_y           <= '0;
            r_mode        <= 1'b0;
            r_steps       <= '0;
            degree_out    <= '0;
            x_out         <= '0;
            y_out         <= '0;
            sector_out    <= SecS1;
            arctan_en_out <= 1'b0;
            wrap_err      <= 1'b0;
        end else begin
            if (w_accept) begin
                r_a     <= AW'(degree_in);
                r_x     <= x_in;
                r_y     <= y_in;
                r_mode  <= arctan_en_in;
                r_steps <= '0;
            end
            unique case (r_state)
                StIdle: begin
                    if (valid_in) r_state <= StReduce;
                end
                StReduce: begin
                    if (r_mode) begin
                        degree_out    <= '0;
                        sector_out    <= r_x[INPUT_WIDTH-1] ? SecS3 : SecS1;
                        x_out         <= r_x[INPUT_WIDTH-1] ? w_neg_x : r_x;
                        y_out         <= r_x[INPUT_WIDTH-1] ? w_neg_y : r_y;
                        arctan_en_out <= 1'b1;
                        r_state       <= StOut;
                    end else if (w_out_range && (r_steps != SW'(MAX_WRAP_STEPS))) begin
                        r_a     <= w_hi ? (r_a - C360) : (r_a + C360);
                        r_steps <= r_steps + 1'b1;
                    end else begin
                        // Bound exhausted: flag it but still emit a result so the pipe never stalls.
                        if (w_out_range) wrap_err <= 1'b1;
                        degree_out    <= OUTPUT_WIDTH'(w_fold_val);
                        sector_out    <= w_fold_sec;
                        x_out         <= r_x;
                        y_out         <= r_y;
                        arctan_en_out <= 1'b0;
                        r_state       <= StOut;
                    end
                end
                StOut: begin
                    if (ready_in) r_state <= valid_in ? StReduce : StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_interface_input_pipe.sv
// Directed bench for interface_input_pipe: scoreboard of expected results, checked when
// valid_out rises, plus backpressure, wrap-bound and mid-transaction reset scenarios.
module tb_interface_input_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_in, valid_in2;
    logic        ready_out, ready_out2;
    logic [15:0] degree_in, x_in, y_in;
    logic        arctan_en_in;
    logic        valid_out, valid_out2;
    logic        ready_in;
    logic        ready_in2;
    logic [15:0] degree_out, degree_out2;
    logic [15:0] x_out, x_out2, y_out, y_out2;
    logic [1:0]  sector_out, sector_out2;
    logic        arctan_en_out, arctan_en_out2;
    logic        wrap_err, wrap_err2;

    always #5 clk = ~clk;

    interface_input_pipe dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .ready_out(ready_out),
        .degree_in(degree_in), .x_in(x_in), .y_in(y_in), .arctan_en_in(arctan_en_in),
        .valid_out(valid_out), .ready_in(ready_in), .degree_out(degree_out),
        .x_out(x_out), .y_out(y_out), .sector_out(sector_out),
        .arctan_en_out(arctan_en_out), .wrap_err(wrap_err)
    );

    interface_input_pipe #(.MAX_WRAP_STEPS(1)) dut2 (
        .clk(clk), .rst(rst), .valid_in(valid_in2), .ready_out(ready_out2),
        .degree_in(degree_in), .x_in(x_in), .y_in(y_in), .arctan_en_in(arctan_en_in),
        .valid_out(valid_out2), .ready_in(ready_in2), .degree_out(degree_out2),
        .x_out(x_out2), .y_out(y_out2), .sector_out(sector_out2),
        .arctan_en_out(arctan_en_out2), .wrap_err(wrap_err2)
    );

    typedef struct packed {
        logic [15:0] deg;
        logic [15:0] x;
        logic [15:0] y;
        logic [1:0]  sec;
        logic        mode;
        logic [7:0]  lat;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until the selected DUT raises valid_out, bounded at 20.
    task automatic wait_valid(input bit second, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (!(second ? valid_out2 : valid_out) && n < 20);
        chk("valid_out_seen", second ? valid_out2 : valid_out, 1'b1);
    endtask

    task automatic compare(input string tag, input bit second, input int n);
        exp_t e;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, sb.size(), 1);
            return;
        end
        e = sb.pop_front();
        chk({tag, "_lat"}, n, e.lat);
        chk({tag, "_deg"}, second ? degree_out2 : degree_out, e.deg);
        chk({tag, "_x"}, second ? x_out2 : x_out, e.x);
        chk({tag, "_y"}, second ? y_out2 : y_out, e.y);
        chk({tag, "_sec"}, second ? sector_out2 : sector_out, e.sec);
        chk({tag, "_mode"}, second ? arctan_en_out2 : arctan_en_out, e.mode);
    endtask

    task automatic send(input bit second, input logic [15:0] d, input logic [15:0] x,
                        input logic [15:0] y, input logic m, input exp_t e);
        sb.push_back(e);
        degree_in    = d;
        x_in         = x;
        y_in         = y;
        arctan_en_in = m;
        if (second) valid_in2 = 1'b1;
        else        valid_in  = 1'b1;
        chk("ready_at_accept", second ? ready_out2 : ready_out, 1'b1);
        tick();
        valid_in  = 1'b0;
        valid_in2 = 1'b0;
    endtask

    task automatic txn(input string tag, input logic [15:0] d, input logic [15:0] x,
                       input logic [15:0] y, input logic m, input logic [15:0] ed,
                       input logic [15:0] ex, input logic [15:0] ey, input logic [1:0] es,
                       input int lat);
        int n;
        send(1'b0, d, x, y, m, '{deg: ed, x: ex, y: ey, sec: es, mode: m, lat: 8'(lat)});
        wait_valid(1'b0, n);
        compare(tag, 1'b0, n);
        tick();
        chk({tag, "_idle_valid"}, valid_out, 1'b0);
    endtask

    int          n;
    logic [15:0] hold_deg, hold_x, hold_y;
    logic [1:0]  hold_sec;

    initial begin
        rst = 1'b1; valid_in = 1'b0; valid_in2 = 1'b0; ready_in = 1'b1; ready_in2 = 1'b1;
        degree_in = '0; x_in = '0; y_in = '0; arctan_en_in = 1'b0;
        tick(); tick();
        rst = 1'b0;

        chk("rst_valid", valid_out, 1'b0);
        chk("rst_ready", ready_out, 1'b1);
        chk("rst_deg", degree_out, 16'h0);
        chk("rst_x", x_out, 16'h0);
        chk("rst_y", y_out, 16'h0);
        chk("rst_sec", sector_out, 2'b00);
        chk("rst_mode", arctan_en_out, 1'b0);
        chk("rst_err", wrap_err, 1'b0);

        // Angle folds (x,y zero so only the angle path matters).
        txn("a45",    16'h02D0, 16'h0, 16'h0, 1'b0, 16'h02D0, 16'h0, 16'h0, 2'b00, 1);
        chk("a45_ready_idle", ready_out, 1'b1);
        txn("a135",   16'h0870, 16'h0, 16'h0, 1'b0, 16'h02D0, 16'h0, 16'h0, 2'b10, 1);
        txn("am135",  16'hF790, 16'h0, 16'h0, 1'b0, 16'h02D0, 16'h0, 16'h0, 2'b11, 1);
        txn("am45",   16'hFD30, 16'h0, 16'h0, 1'b0, 16'h02D0, 16'h0, 16'h0, 2'b01, 1);
        txn("a90",    16'h05A0, 16'h0, 16'h0, 1'b0, 16'h0000, 16'h0, 16'h0, 2'b10, 1);
        txn("a180",   16'h0B40, 16'h0, 16'h0, 1'b0, 16'h05A0, 16'h0, 16'h0, 2'b10, 1);
        txn("am180",  16'hF4C0, 16'h0, 16'h0, 1'b0, 16'h05A0, 16'h0, 16'h0, 2'b10, 2);
        // 1000 -> 640 -> 280 -> -80: three wrap steps, result (S4, 10.0)
        txn("a1000",  16'h3E80, 16'h0, 16'h0, 1'b0, 16'h00A0, 16'h0, 16'h0, 2'b01, 4);
        chk("a1000_no_err", wrap_err, 1'b0);

        // Arctan folds
        txn("at_neg", 16'h1234, 16'hFF9C, 16'h001E, 1'b1, 16'h0, 16'h0064, 16'hFFE2, 2'b11, 1);
        txn("at_min", 16'h0000, 16'h8000, 16'h0005, 1'b1, 16'h0, 16'h7FFF, 16'hFFFB, 2'b11, 1);
        txn("at_pos", 16'h0000, 16'h0032, 16'hFFF9, 1'b1, 16'h0, 16'h0032, 16'hFFF9, 2'b00, 1);

        // Backpressure: hold OUT for 5 cycles, then same-edge handoff.
        ready_in = 1'b0;
        send(1'b0, 16'hFD30, 16'h0, 16'h0, 1'b0,
             '{deg: 16'h02D0, x: 16'h0, y: 16'h0, sec: 2'b01, mode: 1'b0, lat: 8'd1});
        wait_valid(1'b0, n);
        compare("bp", 1'b0, n);
        hold_deg = degree_out; hold_x = x_out; hold_y = y_out; hold_sec = sector_out;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("bp_hold_valid", valid_out, 1'b1);
            chk("bp_hold_ready", ready_out, 1'b0);
            chk("bp_hold_deg", degree_out, hold_deg);
            chk("bp_hold_sec", sector_out, hold_sec);
            chk("bp_hold_xy", {x_out, y_out}, {hold_x, hold_y});
        end
        sb.push_back('{deg: 16'h02D0, x: 16'h0, y: 16'h0, sec: 2'b10, mode: 1'b0, lat: 8'd1});
        degree_in = 16'h0870; arctan_en_in = 1'b0; valid_in = 1'b1; ready_in = 1'b1;
        #1;
        chk("bp_release_ready", ready_out, 1'b1);
        tick();
        valid_in = 1'b0;
        chk("bp_handoff_valid", valid_out, 1'b0);
        chk("bp_handoff_ready", ready_out, 1'b0);
        wait_valid(1'b0, n);
        compare("bp_next", 1'b0, n);
        tick();

        // Wrap bound of 1 step: 1000 -> 640 still out of range -> fold 640 = (S2, 550.0)
        send(1'b1, 16'h3E80, 16'h0, 16'h0, 1'b0,
             '{deg: 16'h2260, x: 16'h0, y: 16'h0, sec: 2'b10, mode: 1'b0, lat: 8'd2});
        wait_valid(1'b1, n);
        compare("bound", 1'b1, n);
        chk("bound_err", wrap_err2, 1'b1);
        tick();
        send(1'b1, 16'h02D0, 16'h0, 16'h0, 1'b0,
             '{deg: 16'h02D0, x: 16'h0, y: 16'h0, sec: 2'b00, mode: 1'b0, lat: 8'd1});
        wait_valid(1'b1, n);
        compare("bound_next", 1'b1, n);
        chk("bound_err_sticky", wrap_err2, 1'b1);
        tick();

        // Reset while the main DUT is reducing 1000.0
        degree_in = 16'h3E80; arctan_en_in = 1'b0; valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        chk("mid_busy", ready_out, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_valid", valid_out, 1'b0);
        chk("mid_rst_ready", ready_out, 1'b1);
        chk("mid_rst_deg", degree_out, 16'h0);
        chk("mid_rst_sec", sector_out, 2'b00);
        chk("mid_rst_xy", {x_out, y_out}, 32'h0);
        chk("mid_rst_err2", wrap_err2, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("mid_rst_stays_idle", valid_out, 1'b0);
        end
        chk("sb_drained", sb.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
